// File: rtl/bmp_frame_buffer.sv
// +----------------------------------------------------------------------------+
// | bmp_frame_buffer                                                           |
// | Clearable BMP frame store with valid/ready write port, 1-cycle read port, |
// | fill counter and sticky out-of-range flag.  Optional macro: BMP_BUF_FWD_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bmp_frame_buffer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 20,
   parameter int DEPTH  = 786486
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              clr_busy,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_dvalid,
   output logic [ADDR_W:0]   wr_count,
   output logic              frame_done,
   output logic              addr_err
);

   localparam int                 c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]    c_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   logic [c_IDX_W-1:0]  r_clr_ptr;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_dvalid;
   logic [ADDR_W:0]     r_wr_count;
   logic                r_addr_err;

   logic                w_run;
   logic                w_wr_acc;
   logic                w_rd_acc;
   logic                w_wr_inr;
   logic                w_rd_inr;
   logic [c_IDX_W-1:0]  w_wr_idx;
   logic [c_IDX_W-1:0]  w_rd_idx;

   assign w_run    = (r_state == S_RUN);
   assign w_wr_acc = wr_valid && w_run;
   assign w_rd_acc = rd_req && w_run;
   assign w_wr_inr = ({1'b0, wr_addr} < c_DEPTH);
   assign w_rd_inr = ({1'b0, rd_addr} < c_DEPTH);
   assign w_wr_idx = wr_addr[c_IDX_W-1:0];
   assign w_rd_idx = rd_addr[c_IDX_W-1:0];

   assign clr_busy   = (r_state == S_CLEAR);
   assign wr_ready   = w_run;
   assign rd_ready   = w_run;
   assign rd_data    = r_rd_data;
   assign rd_dvalid  = r_rd_dvalid;
   assign wr_count   = r_wr_count;
   assign frame_done = (r_wr_count == c_DEPTH);
   assign addr_err   = r_addr_err;

   // Storage has no reset so it maps onto block RAM; the clear engine zeroes it.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_acc && w_wr_inr) begin
         r_mem[w_wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_CLEAR;
         r_clr_ptr   <= '0;
         r_rd_data   <= '0;
         r_rd_dvalid <= 1'b0;
         r_wr_count  <= '0;
         r_addr_err  <= 1'b0;
      end else begin
         r_rd_dvalid <= w_rd_acc;
         if (w_rd_acc) begin
            if (!w_rd_inr) begin
               r_rd_data <= '0;
`ifdef BMP_BUF_FWD_EN
            end else if (w_wr_acc && w_wr_inr && (wr_addr == rd_addr)) begin
               r_rd_data <= wr_data;
`endif
            end else begin
               r_rd_data <= r_mem[w_rd_idx];
            end
         end

         case (r_state)
            S_CLEAR: begin
               if (r_clr_ptr == c_LAST) begin
                  r_state <= S_RUN;
               end else begin
                  r_clr_ptr <= r_clr_ptr + 1'b1;
               end
            end
            S_RUN: begin
               if (clr_req) begin
                  r_state    <= S_CLEAR;
                  r_clr_ptr  <= '0;
                  r_wr_count <= '0;
                  r_addr_err <= 1'b0;
               end else begin
                  // Counts accepted writes, not unique addresses; saturates at DEPTH.
                  if (w_wr_acc && w_wr_inr && (r_wr_count != c_DEPTH)) begin
                     r_wr_count <= r_wr_count + 1'b1;
                  end
                  if ((w_wr_acc && !w_wr_inr) || (w_rd_acc && !w_rd_inr)) begin
                     r_addr_err <= 1'b1;
                  end
               end
            end
            default: r_state <= S_CLEAR;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bmp_frame_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_bmp_frame_buffer                                                        |
// | Scoreboard bench for bmp_frame_buffer at DEPTH=16, ADDR_W=5.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bmp_frame_buffer;

   localparam int c_DATA_W = 8;
   localparam int c_ADDR_W = 5;
   localparam int c_DEPTH  = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clr_req = 1'b0;
   logic                clr_busy;
   logic                wr_valid = 1'b0;
   logic                wr_ready;
   logic [c_ADDR_W-1:0] wr_addr = '0;
   logic [c_DATA_W-1:0] wr_data = '0;
   logic                rd_req = 1'b0;
   logic                rd_ready;
   logic [c_ADDR_W-1:0] rd_addr = '0;
   logic [c_DATA_W-1:0] rd_data;
   logic                rd_dvalid;
   logic [c_ADDR_W:0]   wr_count;
   logic                frame_done;
   logic                addr_err;

   logic [c_DATA_W-1:0] exp_q [$];
   int                  n_vec = 0;
   int                  n_bad = 0;
   int                  n_cyc;

   bmp_frame_buffer #(
      .DATA_W (c_DATA_W),
      .ADDR_W (c_ADDR_W),
      .DEPTH  (c_DEPTH)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req    (clr_req),
      .clr_busy   (clr_busy),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_ready   (rd_ready),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_dvalid  (rd_dvalid),
      .wr_count   (wr_count),
      .frame_done (frame_done),
      .addr_err   (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Read-data monitor: every rd_dvalid pops one expected word.
   always @(negedge clk) begin
      if (rd_dvalid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rd_unexpected: got 0x%0h with rd_dvalid, required no response", rd_data);
         end else begin
            chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic do_write(input int addr, input int data);
      wr_valid = 1'b1;
      wr_addr  = c_ADDR_W'(addr);
      wr_data  = c_DATA_W'(data);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic do_read(input int addr, input int exp);
      rd_req  = 1'b1;
      rd_addr = c_ADDR_W'(addr);
      exp_q.push_back(c_DATA_W'(exp));
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic count_busy(input int pulse_at, output int n);
      n = 0;
      while (clr_busy && n < 200) begin
         @(posedge clk); #1;
         n++;
         clr_req = (n == pulse_at);
      end
      clr_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_clr_busy",   {31'd0, clr_busy},   32'd1);
      chk("rst_wr_ready",   {31'd0, wr_ready},   32'd0);
      chk("rst_rd_ready",   {31'd0, rd_ready},   32'd0);
      chk("rst_rd_data",    {24'd0, rd_data},    32'd0);
      chk("rst_rd_dvalid",  {31'd0, rd_dvalid},  32'd0);
      chk("rst_wr_count",   {26'd0, wr_count},   32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_addr_err",   {31'd0, addr_err},   32'd0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      count_busy(-1, n_cyc);
      chk("init_clear_cycles", n_cyc, 32'd16);
      chk("init_wr_ready", {31'd0, wr_ready}, 32'd1);

      for (int a = 0; a < c_DEPTH; a++) do_read(a, 0);

      do_write(3, 8'hA5);
      do_write(15, 8'h5A);
      do_read(3, 8'hA5);
      do_read(15, 8'h5A);
      chk("wr_count_2",   {26'd0, wr_count},   32'd2);
      chk("frame_done_2", {31'd0, frame_done}, 32'd0);

      // Fill remaining 14 addresses (everything except 3 and 15).
      for (int a = 0; a < 15; a++) begin
         if (a != 3) do_write(a, a);
      end
      chk("wr_count_full",   {26'd0, wr_count},   32'd16);
      chk("frame_done_full", {31'd0, frame_done}, 32'd1);
      do_write(5, 8'h77);
      chk("wr_count_sat",   {26'd0, wr_count},   32'd16);
      chk("frame_done_sat", {31'd0, frame_done}, 32'd1);
      do_read(5, 8'h77);
      do_read(3, 8'hA5);

      chk("addr_err_before", {31'd0, addr_err}, 32'd0);
      do_write(20, 8'hEE);
      chk("addr_err_wr", {31'd0, addr_err}, 32'd1);
      chk("wr_count_oor", {26'd0, wr_count}, 32'd16);
      do_read(20, 0);
      chk("addr_err_rd", {31'd0, addr_err}, 32'd1);

      do_write(4, 8'h11);
      wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 8'h22;
      rd_req   = 1'b1; rd_addr = 5'd4;
`ifdef BMP_BUF_FWD_EN
      exp_q.push_back(8'h22);
`else
      exp_q.push_back(8'h11);
`endif
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_req = 1'b0;
      do_read(4, 8'h22);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_dvalid", {31'd0, rd_dvalid}, 32'd0);
      chk("idle_hold",   {24'd0, rd_data},   32'h22);

      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      chk("clr_busy",       {31'd0, clr_busy},   32'd1);
      chk("clr_wr_ready",   {31'd0, wr_ready},   32'd0);
      chk("clr_addr_err",   {31'd0, addr_err},   32'd0);
      chk("clr_wr_count",   {26'd0, wr_count},   32'd0);
      chk("clr_frame_done", {31'd0, frame_done}, 32'd0);
      count_busy(-1, n_cyc);
      chk("clr_cycles", n_cyc, 32'd16);
      do_read(4, 0);
      do_read(15, 0);

      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",     {31'd0, clr_busy}, 32'd1);
      chk("arst_wr_ready", {31'd0, wr_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      count_busy(5, n_cyc);
      chk("arst_clear_cycles", n_cyc, 32'd16);
      do_write(7, 8'h3C);
      do_read(7, 8'h3C);
      do_read(8, 0);
      chk("arst_wr_count", {26'd0, wr_count}, 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bmp_frame_buffer.md
# bmp_frame_buffer

Parametrised, clearable frame store for BMP byte streams: the successor to the team's write-only BMP RAM. It sits between the BMP parser/converter and the writer stage. Words are written through a valid/ready port and read back through a registered read port with one-cycle latency. A hardware clear engine replaces simulation-only initialisation. The block also tracks fill progress and flags out-of-range accesses.

## Interface
- `DATA_W`, default 8: word width in bits (one BMP byte by default).
- `ADDR_W`, default 20: address width; must satisfy 2^ADDR_W >= DEPTH.
- `DEPTH`, default 786486: number of stored words (54-byte header + 512x512x3 pixels).
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr_req` input 1: one-cycle request to re-clear memory and counters.
- `clr_busy` output 1: clear engine active.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write accepted when `wr_valid && wr_ready`.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input DATA_W: write data.
- `rd_req` input 1: read request; accepted when `rd_req && rd_ready`.
- `rd_ready` output 1: read port available.
- `rd_addr` input ADDR_W: read address.
- `rd_data` output DATA_W: registered read data.
- `rd_dvalid` output 1: `rd_data` valid this cycle.
- `wr_count` output ADDR_W+1: accepted in-range writes since last clear, saturating at DEPTH.
- `frame_done` output 1: `wr_count == DEPTH`.
- `addr_err` output 1: sticky flag, set by any accepted access with address >= DEPTH.

## Operation
- FSM states:
  - CLEAR: pointer `clr_ptr` writes 0 to address `clr_ptr`, one word per cycle, from 0 to DEPTH-1, then goes to RUN.
  - RUN: normal operation.
- `wr_ready = rd_ready = (state == RUN)`; `clr_busy = (state == CLEAR)`.
- Clear requests:
  - `clr_req` in RUN: enter CLEAR next edge with `clr_ptr=0`; `wr_count`, `addr_err` and `frame_done` cleared on that same edge.
  - `clr_req` during CLEAR: ignored.
- Accepted write:
  - Address < DEPTH: stores `wr_data`; `wr_count` increments unless already DEPTH.
  - Address >= DEPTH: dropped, sets `addr_err`, `wr_count` unchanged.
  - `wr_count` counts writes, not unique addresses; rewriting an address still increments it.
- Accepted read:
  - Address < DEPTH: next cycle `rd_data` holds the stored word and `rd_dvalid=1`.
  - Address >= DEPTH: `rd_data=0`, `rd_dvalid=1`, `addr_err` set.
  - Cycles with no accepted read: `rd_dvalid=0` and `rd_data` holds its last value.
- Simultaneous accepted read and write to the same address: behaviour selected by configuration (see below).
- Reset mid-operation (including mid-clear): asynchronously returns to CLEAR with `clr_ptr=0`; memory contents are undefined until the clear completes.

## Timing
- Reset values:
  - state=CLEAR, `clr_ptr=0`, `clr_busy=1`.
  - `wr_ready=0`, `rd_ready=0`.
  - `rd_data=0`, `rd_dvalid=0`.
  - `wr_count=0`, `frame_done=0`, `addr_err=0`.
- Clear duration:
  - After `rst_n` rises, the first edge clears address 0; the DEPTH-th edge clears DEPTH-1 and moves to RUN.
  - `wr_ready`/`rd_ready` are high from the cycle after that edge.
  - First possible accepted write is on edge DEPTH+1.
- From `clr_req` sampled in RUN: busy for exactly DEPTH cycles, then RUN.
- Read latency: 1 cycle, no pipelining stalls; one read and one write may be accepted every cycle.
- `frame_done` and `wr_count` update on the edge that accepts the write.
- `addr_err` sets on the accepting edge.

## Configuration
- `BMP_BUF_FWD_EN` defined: same-cycle same-address read returns the newly written `wr_data` (write-first forwarding).
- `BMP_BUF_FWD_EN` undefined: the read returns the previously stored word (read-first); this is the default, matching plain block-RAM inference.

## Test plan
- Reset, DEPTH=16, ADDR_W=5:
  - `clr_busy=1` for 16 cycles after `rst_n` rises, then `wr_ready=1`.
  - Reading addresses 0..15 returns 0x00 with `rd_dvalid` one cycle after each request.
- Write then read back:
  - Write 0xA5 to address 3 and 0x5A to address 15.
  - Reads return 0xA5 and 0x5A at latency 1.
  - `wr_count=2`, `frame_done=0`.
- Fill and saturation:
  - 16 writes give `frame_done=1`, `wr_count=16`.
  - A 17th in-range write leaves `wr_count=16`.
- Out-of-range access:
  - Write to address 20 is dropped and sets `addr_err=1`.
  - Read of address 20 returns 0x00 with `rd_dvalid=1`.
  - `clr_req` clears `addr_err`.
- Same-address collision: address 4 holds 0x11; write 0x22 and read address 4 in the same cycle.
  - Expect 0x11 without `BMP_BUF_FWD_EN`.
  - Expect 0x22 with it.
- Async reset at clear cycle 7:
  - Clear restarts from 0 and takes the full 16 cycles.
  - `clr_req` issued during CLEAR is ignored: no extension of busy time.
